// File: rtl/fft_6_pkg.sv
// Shared constants and helpers for the 8-point FFT butterfly datapath.
package fft_6_pkg;

    localparam int DEF_DATA_W  = 12;
    localparam int DEF_TW_W    = 12;
    localparam int DEF_TW_FRAC = 7;

    // Half-LSB offset added before the floor shift so the shift rounds half up.
    function automatic int round_const(input int frac);
        return 1 << (frac - 1);
    endfunction

    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int sat_min(input int w);
        return -(1 << (w - 1));
    endfunction

    localparam int ROUND_C = round_const(DEF_TW_FRAC);
    localparam int SAT_MAX = sat_max(DEF_DATA_W);
    localparam int SAT_MIN = sat_min(DEF_DATA_W);

endpackage

// File: rtl/fft_butterfly_6_cmul.sv
// Complex multiply b*W: registered partial products, then combine and round to data scale.
module cmul_6 import fft_6_pkg::*; #(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TW_W    = DEF_TW_W,
    parameter int TW_FRAC = DEF_TW_FRAC
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic signed [DATA_W-1:0]      b_re,
    input  logic signed [DATA_W-1:0]      b_im,
    input  logic signed [TW_W-1:0]        w_re,
    input  logic signed [TW_W-1:0]        w_im,
    output logic signed [DATA_W+TW_W:0]   t_re,
    output logic signed [DATA_W+TW_W:0]   t_im
);

    localparam int PW = DATA_W + TW_W;
    localparam int TW = PW + 1;
    localparam logic signed [TW-1:0] RND = TW'(round_const(TW_FRAC));

    logic signed [PW-1:0] pr1, pr2, pr3, pr4;
    logic signed [TW-1:0] sum_re, sum_im;

    // Product register stage, advancing only when an occupied stage moves.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pr1 <= '0;
            pr2 <= '0;
            pr3 <= '0;
            pr4 <= '0;
        end else if (en) begin
            pr1 <= b_re * w_re;
            pr2 <= b_im * w_im;
            pr3 <= b_re * w_im;
            pr4 <= b_im * w_re;
        end
    end

    // Combine with one guard bit, then round half up via a floor shift.
    always_comb begin
        sum_re = TW'(pr1) - TW'(pr2);
        sum_im = TW'(pr3) + TW'(pr4);
        t_re   = (sum_re + RND) >>> TW_FRAC;
        t_im   = (sum_im + RND) >>> TW_FRAC;
    end

endmodule

// File: rtl/spin_table_6.sv
// Twiddle LUT: W8^idx = exp(-j*2*pi*idx/8) scaled to +-127.
module spin_table_6 import fft_6_pkg::*; #(
    parameter int TW_W = DEF_TW_W
) (
    input  logic        [2:0]      idx,
    output logic signed [TW_W-1:0] w_re,
    output logic signed [TW_W-1:0] w_im
);

    // Eight-entry constant table; 90 approximates 127/sqrt(2).
    always_comb begin
        w_re = '0;
        w_im = '0;
        case (idx)
            3'd0: begin w_re = TW_W'(127);  w_im = TW_W'(0);    end
            3'd1: begin w_re = TW_W'(90);   w_im = TW_W'(-90);  end
            3'd2: begin w_re = TW_W'(0);    w_im = TW_W'(-127); end
            3'd3: begin w_re = TW_W'(-90);  w_im = TW_W'(-90);  end
            3'd4: begin w_re = TW_W'(-127); w_im = TW_W'(0);    end
            3'd5: begin w_re = TW_W'(-90);  w_im = TW_W'(90);   end
            3'd6: begin w_re = TW_W'(0);    w_im = TW_W'(127);  end
            default: begin w_re = TW_W'(90); w_im = TW_W'(90);  end
        endcase
    end

endmodule

// File: rtl/fft_butterfly_6.sv
// Pipelined radix-2 DIT butterfly: X = a + b*W, Y = a - b*W, three stages, valid/ready.
module fft_butterfly_6 import fft_6_pkg::*; #(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TW_W    = DEF_TW_W,
    parameter int TW_FRAC = DEF_TW_FRAC,
    parameter bit SCALE   = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_a_re,
    input  logic signed [DATA_W-1:0] in_a_im,
    input  logic signed [DATA_W-1:0] in_b_re,
    input  logic signed [DATA_W-1:0] in_b_im,
    input  logic        [2:0]        in_tw_idx,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_x_re,
    output logic signed [DATA_W-1:0] out_x_im,
    output logic signed [DATA_W-1:0] out_y_re,
    output logic signed [DATA_W-1:0] out_y_im,
    output logic                     out_sat
);

    localparam int TW = DATA_W + TW_W + 1;
    localparam int SW = TW + 1;
    localparam logic signed [SW-1:0] SAT_HI = SW'(sat_max(DATA_W));
    localparam logic signed [SW-1:0] SAT_LO = SW'(sat_min(DATA_W));

    logic                     v1, v2, v3, adv;
    logic signed [DATA_W-1:0] a1_re, a1_im, b1_re, b1_im, a2_re, a2_im;
    logic signed [TW_W-1:0]   tw_re, tw_im, w1_re, w1_im;
    logic signed [TW-1:0]     t_re, t_im;
    logic signed [SW-1:0]     x_re_f, x_im_f, y_re_f, y_im_f;

    function automatic logic signed [DATA_W-1:0] clip(input logic signed [SW-1:0] v);
        if (v > SAT_HI) return SAT_HI[DATA_W-1:0];
        else if (v < SAT_LO) return SAT_LO[DATA_W-1:0];
        else return v[DATA_W-1:0];
    endfunction

    function automatic logic clips(input logic signed [SW-1:0] v);
        return (v > SAT_HI) || (v < SAT_LO);
    endfunction

    // Whole pipeline moves as one unless the output stage is full and blocked.
    assign adv       = out_ready | ~v3;
    assign in_ready  = adv;
    assign out_valid = v3;

    spin_table_6 #(.TW_W(TW_W)) u_spin (
        .idx  (in_tw_idx),
        .w_re (tw_re),
        .w_im (tw_im)
    );

    cmul_6 #(.DATA_W(DATA_W), .TW_W(TW_W), .TW_FRAC(TW_FRAC)) u_cmul (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (adv & v1),
        .b_re  (b1_re),
        .b_im  (b1_im),
        .w_re  (w1_re),
        .w_im  (w1_im),
        .t_re  (t_re),
        .t_im  (t_im)
    );

    // Full-width add/sub; optional halving with round half up before the clamp.
    always_comb begin
        x_re_f = SW'(a2_re) + SW'(t_re);
        x_im_f = SW'(a2_im) + SW'(t_im);
        y_re_f = SW'(a2_re) - SW'(t_re);
        y_im_f = SW'(a2_im) - SW'(t_im);
        if (SCALE) begin
            x_re_f = (x_re_f + SW'(1)) >>> 1;
            x_im_f = (x_im_f + SW'(1)) >>> 1;
            y_re_f = (y_re_f + SW'(1)) >>> 1;
            y_im_f = (y_im_f + SW'(1)) >>> 1;
        end
    end

    // Stage valids and data; data registers load only behind a valid sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            v3       <= 1'b0;
            a1_re    <= '0;
            a1_im    <= '0;
            b1_re    <= '0;
            b1_im    <= '0;
            w1_re    <= '0;
            w1_im    <= '0;
            a2_re    <= '0;
            a2_im    <= '0;
            out_x_re <= '0;
            out_x_im <= '0;
            out_y_re <= '0;
            out_y_im <= '0;
            out_sat  <= 1'b0;
        end else if (adv) begin
            v1 <= in_valid;
            v2 <= v1;
            v3 <= v2;
            if (in_valid) begin
                a1_re <= in_a_re;
                a1_im <= in_a_im;
                b1_re <= in_b_re;
                b1_im <= in_b_im;
                w1_re <= tw_re;
                w1_im <= tw_im;
            end
            if (v1) begin
                a2_re <= a1_re;
                a2_im <= a1_im;
            end
            if (v2) begin
                out_x_re <= clip(x_re_f);
                out_x_im <= clip(x_im_f);
                out_y_re <= clip(y_re_f);
                out_y_im <= clip(y_im_f);
                out_sat  <= clips(x_re_f) | clips(x_im_f) | clips(y_re_f) | clips(y_im_f);
            end
        end
    end

endmodule

// File: tb/tb_fft_butterfly_6.sv
// Directed bench for fft_butterfly_6 (SCALE=0 and SCALE=1 instances on shared inputs).
module tb_fft_butterfly_6;

    logic clk = 1'b0;
    logic rst_n, in_valid, out_ready;
    logic signed [11:0] in_a_re, in_a_im, in_b_re, in_b_im;
    logic [2:0] in_tw_idx;

    logic in_ready, out_valid, out_sat;
    logic signed [11:0] out_x_re, out_x_im, out_y_re, out_y_im;
    logic in_ready_s, out_valid_s, out_sat_s;
    logic signed [11:0] out_x_re_s, out_x_im_s, out_y_re_s, out_y_im_s;

    int n_checks = 0;
    int n_fail   = 0;

    int v_ar[256], v_ai[256], v_br[256], v_bi[256], v_idx[256];
    int e_xr[256], e_xi[256], e_yr[256], e_yi[256], e_s[256];

    always #5 clk = ~clk;

    fft_butterfly_6 #(.SCALE(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a_re(in_a_re), .in_a_im(in_a_im), .in_b_re(in_b_re), .in_b_im(in_b_im),
        .in_tw_idx(in_tw_idx), .out_valid(out_valid), .out_ready(out_ready),
        .out_x_re(out_x_re), .out_x_im(out_x_im), .out_y_re(out_y_re), .out_y_im(out_y_im),
        .out_sat(out_sat)
    );

    fft_butterfly_6 #(.SCALE(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_a_re(in_a_re), .in_a_im(in_a_im), .in_b_re(in_b_re), .in_b_im(in_b_im),
        .in_tw_idx(in_tw_idx), .out_valid(out_valid_s), .out_ready(out_ready),
        .out_x_re(out_x_re_s), .out_x_im(out_x_im_s), .out_y_re(out_y_re_s),
        .out_y_im(out_y_im_s), .out_sat(out_sat_s)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int clamp(input int v);
        if (v > 2047) return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    // Reference butterfly for SCALE=0 with an independently written twiddle table.
    function automatic void model(input int ar, input int ai, input int br, input int bi,
                                  input int idx, output int xr, output int xi,
                                  output int yr, output int yi, output int s);
        int wr[8] = '{127, 90, 0, -90, -127, -90, 0, 90};
        int wi[8] = '{0, -90, -127, -90, 0, 90, 127, 90};
        int tr, ti, fx, fy, gx, gy;
        tr = br * wr[idx] - bi * wi[idx];
        ti = br * wi[idx] + bi * wr[idx];
        tr = (tr + 64) >>> 7;
        ti = (ti + 64) >>> 7;
        fx = ar + tr; gx = ai + ti; fy = ar - tr; gy = ai - ti;
        xr = clamp(fx); xi = clamp(gx); yr = clamp(fy); yi = clamp(gy);
        s = ((xr != fx) || (xi != gx) || (yr != fy) || (yi != gy)) ? 1 : 0;
    endfunction

    task automatic drive(input int ar, input int ai, input int br, input int bi, input int idx);
        in_a_re   = 12'(ar);
        in_a_im   = 12'(ai);
        in_b_re   = 12'(br);
        in_b_im   = 12'(bi);
        in_tw_idx = 3'(idx);
    endtask

    // One sample on an idle pipe; leaves us at the negedge where out_valid is first seen.
    task automatic send_one(input string tag, input int ar, input int ai, input int br,
                            input int bi, input int idx);
        int lat;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        drive(ar, ai, br, bi, idx);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "_latency"}, lat, 3);
    endtask

    // Streams n vectors from the tables; ready pattern 1,0,0 repeating or random.
    task automatic run_stream(input string tag, input int n, input bit rnd_ready);
        int tx = 0, rx = 0, cyc = 0;
        while (rx < n && cyc < 2000) begin
            @(negedge clk);
            if (out_valid && rx < n) begin
                check_eq({tag, "_x_re"}, out_x_re, e_xr[rx]);
                check_eq({tag, "_x_im"}, out_x_im, e_xi[rx]);
                check_eq({tag, "_y_re"}, out_y_re, e_yr[rx]);
                check_eq({tag, "_y_im"}, out_y_im, e_yi[rx]);
                check_eq({tag, "_sat"}, out_sat, e_s[rx]);
            end
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : (cyc % 3 == 0);
            in_valid  = (tx < n);
            if (tx < n) drive(v_ar[tx], v_ai[tx], v_br[tx], v_bi[tx], v_idx[tx]);
            #1;
            check_eq({tag, "_in_ready"}, in_ready, !(out_valid && !out_ready));
            if (in_valid && in_ready) tx++;
            if (out_valid && out_ready) rx++;
            cyc++;
        end
        check_eq({tag, "_count"}, rx, n);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq({tag, "_no_extra"}, out_valid, 0);
    endtask

    initial begin
        int hx_re[8] = '{109, 80, 10, -60, -89, -60, 10, 80};
        int hx_im[8] = '{20, -50, -79, -50, 20, 90, 119, 90};
        int hy_re[8] = '{-89, -60, 10, 80, 109, 80, 10, -60};
        int hy_im[8] = '{20, 90, 119, 90, 20, -50, -79, -50};
        int seen;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drive(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_x_re", out_x_re, 0);
        check_eq("rst_sat", out_sat, 0);
        rst_n = 1'b1;

        // Identity twiddle
        send_one("t1", 100, 0, 100, 0, 0);
        check_eq("t1_x_re", out_x_re, 199);
        check_eq("t1_x_im", out_x_im, 0);
        check_eq("t1_y_re", out_y_re, 1);
        check_eq("t1_y_im", out_y_im, 0);
        check_eq("t1_sat", out_sat, 0);

        // W = -j
        send_one("t2", 100, 0, 100, 0, 2);
        check_eq("t2_x_re", out_x_re, 100);
        check_eq("t2_x_im", out_x_im, -99);
        check_eq("t2_y_re", out_y_re, 100);
        check_eq("t2_y_im", out_y_im, 99);
        check_eq("t2_sat", out_sat, 0);

        // Positive clip, and the halving instance keeping it in range
        send_one("t3", 2047, 0, 2047, 0, 0);
        check_eq("t3_x_re", out_x_re, 2047);
        check_eq("t3_y_re", out_y_re, 16);
        check_eq("t3_sat", out_sat, 1);
        check_eq("t3s_valid", out_valid_s, 1);
        check_eq("t3s_x_re", out_x_re_s, 2039);
        check_eq("t3s_x_im", out_x_im_s, 0);
        check_eq("t3s_y_re", out_y_re_s, 8);
        check_eq("t3s_sat", out_sat_s, 0);

        // Negative clip through W = -1
        send_one("tn", -2048, 0, 2047, 0, 4);
        check_eq("tn_x_re", out_x_re, -2048);
        check_eq("tn_y_re", out_y_re, -17);
        check_eq("tn_sat", out_sat, 1);

        // All eight twiddles back to back under backpressure
        for (int k = 0; k < 8; k++) begin
            v_ar[k] = 10; v_ai[k] = 20; v_br[k] = 100; v_bi[k] = 0; v_idx[k] = k;
            e_xr[k] = hx_re[k]; e_xi[k] = hx_im[k];
            e_yr[k] = hy_re[k]; e_yi[k] = hy_im[k]; e_s[k] = 0;
        end
        run_stream("t4", 8, 1'b0);

        // Reset with three samples in flight
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1;
        drive(100, 0, 100, 0, 0);
        repeat (3) @(negedge clk);
        check_eq("t5_full_valid", out_valid, 1);
        check_eq("t5_full_in_ready", in_ready, 0);
        in_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        check_eq("t5_out_valid", out_valid, 0);
        check_eq("t5_x_re", out_x_re, 0);
        check_eq("t5_y_re", out_y_re, 0);
        check_eq("t5_sat", out_sat, 0);
        check_eq("t5_in_ready", in_ready, 1);
        rst_n = 1'b1; out_ready = 1'b1; seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        check_eq("t5_no_stale", seen, 0);

        // Random operands and backpressure against the reference
        for (int k = 0; k < 200; k++) begin
            v_ar[k] = int'($urandom_range(0, 4095)) - 2048;
            v_ai[k] = int'($urandom_range(0, 4095)) - 2048;
            v_br[k] = int'($urandom_range(0, 4095)) - 2048;
            v_bi[k] = int'($urandom_range(0, 4095)) - 2048;
            v_idx[k] = int'($urandom_range(0, 7));
            model(v_ar[k], v_ai[k], v_br[k], v_bi[k], v_idx[k],
                  e_xr[k], e_xi[k], e_yr[k], e_yi[k], e_s[k]);
        end
        run_stream("t6", 200, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
